biquad_seq_ctrl: RTL and testbench

//  Sequencer and state-register stage for the second-order IIR (DF-II biquad).

---
 rtl/biquad_seq_ctrl_pkg.sv | 30 +++
 rtl/biquad_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_biquad_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/biquad_seq_ctrl_pkg.sv
// Shared widths and mux select encodings for the DF-II biquad datapath.
// The operand mux and the sequencer both import this so the codes stay in step.
package biquad_seq_ctrl_pkg;

  localparam int unsigned N = 24;
  localparam int unsigned F = 15;

  // Coefficient select (controlS)
  localparam logic [2:0] SEL_CERO_S = 3'b000;
  localparam logic [2:0] SEL_A1     = 3'b001;
  localparam logic [2:0] SEL_A2     = 3'b010;
  localparam logic [2:0] SEL_B0     = 3'b011;
  localparam logic [2:0] SEL_B1     = 3'b100;
  localparam logic [2:0] SEL_B2     = 3'b101;

  // State select (controlC)
  localparam logic [1:0] SEL_CERO_C = 2'b00;
  localparam logic [1:0] SEL_FK1    = 2'b01;
  localparam logic [1:0] SEL_FK2    = 2'b10;
  localparam logic [1:0] SEL_FK     = 2'b11;

  // Addend select (controlZ)
  localparam logic [2:0] SEL_CERO_Z = 3'b000;
  localparam logic [2:0] SEL_UK     = 3'b001;
  localparam logic [2:0] SEL_YK     = 3'b010;
  localparam logic [2:0] SEL_ACUM1  = 3'b011;
  localparam logic [2:0] SEL_ACUM2  = 3'b100;
  localparam logic [2:0] SEL_ACUM3  = 3'b101;

endpackage

// File: rtl/biquad_seq_ctrl.sv
// Biquad sequencer: steps the operand mux through five MAC steps and registers results.
// Define BIQUAD_MAC_PIPE_EN to stretch each step to two cycles for a registered MAC.
module biquad_seq_ctrl
  import biquad_seq_ctrl_pkg::*;
#(
  parameter int unsigned W = N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_tick,
  input  logic [W-1:0] Uk_in,
  input  logic [W-1:0] mac_sum,
  output logic [2:0]   controlS,
  output logic [1:0]   controlC,
  output logic [2:0]   controlZ,
  output logic [W-1:0] Uk,
  output logic [W-1:0] fk,
  output logic [W-1:0] fk1,
  output logic [W-1:0] fk2,
  output logic [W-1:0] yk,
  output logic [W-1:0] acum1,
  output logic [W-1:0] acum2,
  output logic [W-1:0] acum3,
  output logic         busy,
  output logic         done,
  output logic         overrun
);

  typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, S5, UPD} state_t;

  state_t state, state_n;
  logic   in_step;
  logic   step_end;

  assign in_step = (state != IDLE) && (state != UPD);

`ifdef BIQUAD_MAC_PIPE_EN
  // Second cycle of a step; the registered MAC output is valid only then.
  logic half;

  always_ff @(posedge clk) begin
    if (reset) begin
      half <= 1'b0;
    end else if (in_step) begin
      half <= ~half;
    end else begin
      half <= 1'b0;
    end
  end

  assign step_end = half;
`else
  assign step_end = 1'b1;
`endif

  always_comb begin
    controlS = SEL_CERO_S;
    controlC = SEL_CERO_C;
    controlZ = SEL_CERO_Z;
    state_n  = state;
    unique case (state)
      IDLE: if (sample_tick) state_n = S1;
      S1: begin
        controlS = SEL_A1;
        controlC = SEL_FK1;
        controlZ = SEL_UK;
        if (step_end) state_n = S2;
      end
      S2: begin
        controlS = SEL_A2;
        controlC = SEL_FK2;
        controlZ = SEL_ACUM1;
        if (step_end) state_n = S3;
      end
      S3: begin
        controlS = SEL_B0;
        controlC = SEL_FK;
        controlZ = SEL_CERO_Z;
        if (step_end) state_n = S4;
      end
      S4: begin
        controlS = SEL_B1;
        controlC = SEL_FK1;
        controlZ = SEL_ACUM2;
        if (step_end) state_n = S5;
      end
      S5: begin
        controlS = SEL_B2;
        controlC = SEL_FK2;
        controlZ = SEL_ACUM3;
        if (step_end) state_n = UPD;
      end
      UPD:     state_n = sample_tick ? S1 : IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign done    = (state == UPD);
  assign overrun = sample_tick && in_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      Uk    <= '0;
      fk    <= '0;
      fk1   <= '0;
      fk2   <= '0;
      yk    <= '0;
      acum1 <= '0;
      acum2 <= '0;
      acum3 <= '0;
    end else begin
      state <= state_n;
      if (!in_step && sample_tick) Uk <= Uk_in;
      if (step_end) begin
        case (state)
          S1:      acum1 <= mac_sum;
          S2:      fk    <= mac_sum;
          S3:      acum2 <= mac_sum;
          S4:      acum3 <= mac_sum;
          S5:      yk    <= mac_sum;
          default: ;
        endcase
      end
      if (state == UPD) begin
        fk2 <= fk1;
        fk1 <= fk;
      end
    end
  end

endmodule

// File: tb/tb_biquad_seq_ctrl.sv
// Scoreboard bench for biquad_seq_ctrl: a driver predicts each sample's results with a
// sample-level filter model, and a negedge monitor checks controls, flags and results.
module tb_biquad_seq_ctrl;
  import biquad_seq_ctrl_pkg::*;

`ifdef BIQUAD_MAC_PIPE_EN
  localparam int P = 2;
`else
  localparam int P = 1;
`endif
  localparam int LAT = 5 * P + 1;

  localparam logic signed [N-1:0] CA1 = 24'sd64225;
  localparam logic signed [N-1:0] CA2 = -24'sd32112;
  localparam logic signed [N-1:0] CB0 = 24'sd6;
  localparam logic signed [N-1:0] CB1 = 24'sd13;
  localparam logic signed [N-1:0] CB2 = 24'sd9;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sample_tick = 1'b0;
  logic [N-1:0] Uk_in = '0;
  logic [N-1:0] mac_sum;
  logic [2:0]   controlS;
  logic [1:0]   controlC;
  logic [2:0]   controlZ;
  logic [N-1:0] Uk, fk, fk1, fk2, yk, acum1, acum2, acum3;
  logic         busy, done, overrun;

  biquad_seq_ctrl #(.W(N)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .Uk_in(Uk_in), .mac_sum(mac_sum),
    .controlS(controlS), .controlC(controlC), .controlZ(controlZ),
    .Uk(Uk), .fk(fk), .fk1(fk1), .fk2(fk2), .yk(yk),
    .acum1(acum1), .acum2(acum2), .acum3(acum3),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic signed [N-1:0] mac(input logic signed [N-1:0] c,
                                              input logic signed [N-1:0] x,
                                              input logic signed [N-1:0] z);
    logic signed [2*N-1:0] p;
    p = c * x;
    p = p >>> F;
    return p[N-1:0] + z;
  endfunction

  // Combinational coefficient/operand mux and MAC around the DUT.
  logic signed [N-1:0] ms, mc, mz;
  always_comb begin
    ms = '0;
    mc = '0;
    mz = '0;
    case (controlS)
      SEL_A1:  ms = CA1;
      SEL_A2:  ms = CA2;
      SEL_B0:  ms = CB0;
      SEL_B1:  ms = CB1;
      SEL_B2:  ms = CB2;
      default: ms = '0;
    endcase
    case (controlC)
      SEL_FK1: mc = fk1;
      SEL_FK2: mc = fk2;
      SEL_FK:  mc = fk;
      default: mc = '0;
    endcase
    case (controlZ)
      SEL_UK:    mz = Uk;
      SEL_YK:    mz = yk;
      SEL_ACUM1: mz = acum1;
      SEL_ACUM2: mz = acum2;
      SEL_ACUM3: mz = acum3;
      default:   mz = '0;
    endcase
    mac_sum = mac(ms, mc, mz);
  end

  typedef struct {
    int           cyc;
    logic [N-1:0] uk;
    logic [N-1:0] fk;
    logic [N-1:0] yk;
  } ent_t;

  ent_t sb[$];
  int   cyc = 0;
  logic rst_seen = 1'b0;
  int   t_acc = -1000;
  int   t_prev = -1000;
  int   busy_until = 0;
  logic fin = 1'b0;
  logic signed [N-1:0] m_fk1 = '0, m_fk2 = '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  task automatic clear_model();
    sb.delete();
    t_acc      = -1000;
    t_prev     = -1000;
    busy_until = 0;
    m_fk1      = '0;
    m_fk2      = '0;
  endtask

  // One cycle of stimulus; accepted ticks run the whole filter equation at once.
  task automatic step(input logic tk, input int uk);
    logic signed [N-1:0] u, a1v, f, a2v, a3v, y;
    ent_t e;
    @(posedge clk);
    #1;
    sample_tick = tk;
    Uk_in       = N'(uk);
    if (tk && cyc >= busy_until) begin
      u   = N'(uk);
      a1v = mac(CA1, m_fk1, u);
      f   = mac(CA2, m_fk2, a1v);
      a2v = mac(CB0, f, '0);
      a3v = mac(CB1, m_fk1, a2v);
      y   = mac(CB2, m_fk2, a3v);
      m_fk2 = m_fk1;
      m_fk1 = f;
      e.cyc = cyc + LAT;
      e.uk  = u;
      e.fk  = f;
      e.yk  = y;
      sb.push_back(e);
      t_prev     = t_acc;
      t_acc      = cyc;
      busy_until = cyc + LAT;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    sample_tick = 1'b0;
    @(posedge clk);
    #1;
    clear_model();
    repeat (n - 1) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset(3);
    // Impulse response, two samples
    step(1'b1, 32768);
    repeat (LAT) step(1'b0, 0);
    step(1'b1, 0);
    repeat (LAT) step(1'b0, 0);
    // Second tick at t+3 is an overrun
    step(1'b1, 500);
    repeat (2) step(1'b0, 0);
    step(1'b1, 777);
    repeat (LAT) step(1'b0, 0);
    // Reset while in S3
    step(1'b1, 1000);
    repeat (2 * P) step(1'b0, 0);
    do_reset(1);
    repeat (2) step(1'b0, 0);
    // Tick landing in UPD
    step(1'b1, 300);
    repeat (LAT - 1) step(1'b0, 0);
    step(1'b1, -200);
    repeat (LAT) step(1'b0, 0);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) == 0), int'($urandom_range(0, 4000)) - 2000);
    end
    repeat (LAT + 2) step(1'b0, 0);
    fin = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  logic [2:0] ts[5] = '{SEL_A1, SEL_A2, SEL_B0, SEL_B1, SEL_B2};
  logic [1:0] tc[5] = '{SEL_FK1, SEL_FK2, SEL_FK, SEL_FK1, SEL_FK2};
  logic [2:0] tz[5] = '{SEL_UK, SEL_ACUM1, SEL_CERO_Z, SEL_ACUM2, SEL_ACUM3};

  always @(negedge clk) begin
    int k, kk;
    logic [2:0] es, ez;
    logic [1:0] ec;
    logic eb, ed, eo;
    ent_t e;
    k  = cyc - t_acc;
    kk = cyc - t_prev;
    es = '0;
    ec = '0;
    ez = '0;
    eb = 1'b0;
    ed = 1'b0;
    eo = 1'b0;
    if (k >= 1 && k <= 5 * P) begin
      es = ts[(k - 1) / P];
      ec = tc[(k - 1) / P];
      ez = tz[(k - 1) / P];
      eb = 1'b1;
      eo = sample_tick;
    end else if (k == LAT || kk == LAT) begin
      eb = 1'b1;
      ed = 1'b1;
    end
    chk("controls", {controlS, controlC, controlZ}, {es, ec, ez});
    chk("busy", busy, eb);
    chk("done", done, ed);
    chk("overrun", overrun, eo);
    if (rst_seen) begin
      chk("reset_data", {Uk, fk, fk1, fk2, yk, acum1, acum2, acum3}, '0);
    end
    if (done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("Uk", Uk, e.uk);
        chk("fk", fk, e.fk);
        chk("yk", yk, e.yk);
      end
    end
    if (fin) begin
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

endmodule
